hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait hold and
// optional multi-cycle (mul/div) hold, enabled by defining HAZARD_CTRL_MULDIV_EN.
module hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            idex_memread,
    input  logic [RF_ADDRESS-1:0] idex_rd,
    input  logic [RF_ADDRESS-1:0] ifid_rs1,
    input  logic [RF_ADDRESS-1:0] ifid_rs2,
    input  logic                  ifid_use_rs1,
    input  logic                  ifid_use_rs2,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  muldiv_start,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_hold,
    output logic                  idex_bubble,
    output logic                  exmem_hold,
    output logic                  exmem_bubble,
    output logic                  muldiv_done,
    output logic                  busy_state,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int LAT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;
    logic             start_eff;

`ifdef HAZARD_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;

    // Counter holds the number of held cycles still owed after the current one;
    // mem_busy freezes both state and count so the op is stretched, not shortened.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            lat_cnt <= '0;
        end else if (!mem_busy) begin
            case (state)
                ST_RUN: begin
                    if (!branch_taken && start_eff) begin
                        state   <= ST_MULDIV;
                        lat_cnt <= LAT_W'(MULDIV_LAT - 1);
                    end
                end
                ST_MULDIV: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    lat_cnt <= '0;
                end
            endcase
        end
    end
`else
    localparam bit MD_EN = 1'b0;

    assign state   = ST_RUN;
    assign lat_cnt = '0;
`endif

    assign start_eff = muldiv_start & MD_EN;

    always_comb begin
        load_use = (idex_memread != 3'b000) && (idex_rd != '0) &&
                   ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                    (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        exmem_bubble = 1'b0;
        muldiv_done  = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else if (state == ST_MULDIV) begin
            if (lat_cnt != '0) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
            end else begin
                muldiv_done = 1'b1;
            end
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (start_eff) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Reset cycles never count; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign busy_state   = !reset && (state == ST_MULDIV);
    assign stall_cycles = reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs from a
// behavioural model, a monitor pops and compares each cycle on the falling edge.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] idex_memread = '0;
    logic [4:0] idex_rd = '0;
    logic [4:0] ifid_rs1 = '0;
    logic [4:0] ifid_rs2 = '0;
    logic       ifid_use_rs1 = 1'b0;
    logic       ifid_use_rs2 = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_busy = 1'b0;
    logic       muldiv_start = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble;
    logic        exmem_hold, exmem_bubble, muldiv_done, busy_state;
    logic [15:0] stall_cycles;
    logic        pc_write4, ifid_write4, ifid_flush4, idex_hold4, idex_bubble4;
    logic        exmem_hold4, exmem_bubble4, muldiv_done4, busy_state4;
    logic [3:0]  stall_cycles4;

    always #5 clk = ~clk;

    hazard_ctrl #(.RF_ADDRESS(5), .MULDIV_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .muldiv_start(muldiv_start), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .exmem_bubble(exmem_bubble), .muldiv_done(muldiv_done),
        .busy_state(busy_state), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.RF_ADDRESS(5), .MULDIV_LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .muldiv_start(muldiv_start), .pc_write(pc_write4), .ifid_write(ifid_write4),
        .ifid_flush(ifid_flush4), .idex_hold(idex_hold4), .idex_bubble(idex_bubble4),
        .exmem_hold(exmem_hold4), .exmem_bubble(exmem_bubble4), .muldiv_done(muldiv_done4),
        .busy_state(busy_state4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        logic [8:0] ctl;
        int         st16;
        int         st4;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

`ifdef HAZARD_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // Reference model state: whether a multi-cycle op is running and how many
    // cycles of it have elapsed; plus the two saturating stall counts.
    bit in_op = 1'b0;
    int op_elapsed = 0;
    int stall16 = 0;
    int stall4 = 0;

    // ctl = {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
    //        exmem_hold, exmem_bubble, muldiv_done, busy_state}
    task automatic model_step(output exp_t e);
        bit pc, ifw, fl, ih, ib, eh, eb, dn, bs, lu;
        pc = 1; ifw = 1; fl = 0; ih = 0; ib = 0; eh = 0; eb = 0; dn = 0; bs = 0;
        if (reset) begin
            e.ctl = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            e.st16 = 0;
            e.st4 = 0;
            in_op = 0;
            op_elapsed = 0;
            stall16 = 0;
            stall4 = 0;
            return;
        end
        e.st16 = stall16;
        e.st4 = stall4;
        bs = in_op;
        lu = (idex_memread != 0) && (idex_rd != 0) &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        if (mem_busy) begin
            pc = 0; ifw = 0; ih = 1; eh = 1;
        end else if (in_op) begin
            if (op_elapsed < LAT) begin
                pc = 0; ifw = 0; ih = 1; eb = 1;
                op_elapsed++;
            end else begin
                dn = 1;
                in_op = 0;
            end
        end else if (branch_taken) begin
            fl = 1; ib = 1;
        end else if (MD_EN && muldiv_start) begin
            pc = 0; ifw = 0; ih = 1; eb = 1;
            in_op = 1;
            op_elapsed = 1;
        end else if (lu) begin
            pc = 0; ifw = 0; ib = 1;
        end
        if (!pc) begin
            if (stall16 < 65535) stall16++;
            if (stall4 < 15) stall4++;
        end
        e.ctl = {pc, ifw, fl, ih, ib, eh, eb, dn, bs};
    endtask

    task automatic cyc(input bit r, input bit mb, input bit br, input bit ms,
                       input logic [2:0] mr, input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input bit u1, input bit u2);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; mem_busy = mb; branch_taken = br; muldiv_start = ms;
        idex_memread = mr; idex_rd = rd; ifid_rs1 = s1; ifid_rs2 = s2;
        ifid_use_rs1 = u1; ifid_use_rs2 = u2;
        model_step(e);
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic monitor();
        exp_t        e;
        logic [8:0]  got, got4;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
                       exmem_hold, exmem_bubble, muldiv_done, busy_state};
                got4 = {pc_write4, ifid_write4, ifid_flush4, idex_hold4, idex_bubble4,
                        exmem_hold4, exmem_bubble4, muldiv_done4, busy_state4};
                checks += 4;
                if (got !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
                end
                if (got4 !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl4 t=%0t got=%b want=%b", $time, got4, e.ctl);
                end
                if (stall_cycles !== 16'(e.st16)) begin
                    failures++;
                    $display("FAIL stall16 t=%0t got=%0d want=%0d", $time, stall_cycles, e.st16);
                end
                if (stall_cycles4 !== 4'(e.st4)) begin
                    failures++;
                    $display("FAIL stall4 t=%0t got=%0d want=%0d", $time, stall_cycles4, e.st4);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        cyc(1, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();

        // Load-use on rs1, then the re-evaluated cycle
        cyc(0, 0, 0, 0, 3'b010, 5'd5, 5'd5, 5'd0, 1, 0);
        idle();
        // No stall: destination x0, or source not read
        cyc(0, 0, 0, 0, 3'b010, 5'd0, 5'd0, 5'd0, 1, 1);
        cyc(0, 0, 0, 0, 3'b010, 5'd5, 5'd5, 5'd3, 0, 1);
        // Load-use on rs2
        cyc(0, 0, 0, 0, 3'b100, 5'd7, 5'd1, 5'd7, 1, 1);
        // Branch wins over load-use
        cyc(0, 0, 1, 0, 3'b010, 5'd5, 5'd5, 5'd0, 1, 0);
        idle();

        // Multi-cycle op, then one with mem_busy inserted mid-op
        cyc(0, 0, 0, 1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (6) cyc(0, 0, 1, 1, 3'b010, 5'd5, 5'd5, 5'd0, 1, 0);
        cyc(0, 0, 0, 1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        repeat (2) cyc(0, 1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (5) idle();

        // Reset in the middle of an op
        cyc(0, 0, 0, 1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        cyc(1, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (6) idle();

        // Long memory wait saturates the narrow counter
        repeat (20) cyc(0, 1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (2) idle();

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 12),
                ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end
        idle();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
